// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
// Serial stimulus source for the 01[0*]1 sequence detector. On start it
// shifts out num_patterns copies of "0,1,<num_zeros x 0>,1" on bit_out,
// with each bit held for DIV_VALUE+1 clocks. A two-digit active-low 7-seg
// readout shows how many patterns have been fully sent.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | waiting for start; outputs quiet
//  S_0   | leading 0 bit of a pattern
//  S_1A  | first 1 bit of a pattern
//  S_Z   | run of num_zeros 0 bits (one strobe per zero)
//  S_1B  | closing 1 bit; pattern counted at its end
//  DONE  | one-clock done pulse, then back to IDLE
module seq_pattern_tx #(
  parameter int DIV_VALUE = 2
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [5:0] num_zeros,
  input  logic [5:0] num_patterns,
  output logic       bit_out,
  output logic       bit_strobe,
  output logic       busy,
  output logic       done,
  output logic [5:0] sent_count,
  output logic [6:0] DISP0,
  output logic [6:0] DISP1
);

  // Divider width covers 0..DIV_VALUE (24 bits for the FPGA setting).
  localparam int DIV_W = (DIV_VALUE > 0) ? $clog2(DIV_VALUE + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_VALUE);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S_0  = 3'd1,
    S_1A = 3'd2,
    S_Z  = 3'd3,
    S_1B = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [5:0]       zero_cnt, zero_nxt;
  logic [5:0]       zeros_q, zeros_nxt;
  logic [5:0]       pats_q, pats_nxt;
  logic [5:0]       sent_nxt;
  logic             bit_nxt, strobe_nxt, busy_nxt, done_nxt;
  logic             bit_end;
  logic [5:0]       zero_inc, sent_inc;
  logic [3:0]       ones_digit, tens_digit;

  // Active-low segment encoding {g..a} for a single decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign bit_end  = (div_cnt == DIV_LAST);
  assign zero_inc = zero_cnt + 6'd1;
  assign sent_inc = sent_count + 6'd1;

  // State register.
  always_ff @(posedge clk_50MHz) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and next-output decode; all outputs are registered from here.
  always_comb begin
    state_nxt  = state;
    div_nxt    = '0;
    zero_nxt   = zero_cnt;
    zeros_nxt  = zeros_q;
    pats_nxt   = pats_q;
    sent_nxt   = sent_count;
    bit_nxt    = bit_out;
    strobe_nxt = 1'b0;
    busy_nxt   = busy;
    done_nxt   = 1'b0;

    case (state)
      IDLE: begin
        bit_nxt  = 1'b0;
        busy_nxt = 1'b0;
        zero_nxt = '0;
        if (start) begin
          zeros_nxt = num_zeros;
          pats_nxt  = num_patterns;
          sent_nxt  = '0;
          if (num_patterns == 6'd0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt  = S_0;
            busy_nxt   = 1'b1;
            strobe_nxt = 1'b1;
          end
        end
      end

      S_0, S_1A, S_Z, S_1B: begin
        if (abort) begin
          // Abort drops straight to IDLE; the partial count is kept visible.
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          bit_nxt   = 1'b0;
          zero_nxt  = '0;
        end else if (!bit_end) begin
          div_nxt = div_cnt + DIV_W'(1);
        end else begin
          strobe_nxt = 1'b1;
          case (state)
            S_0: begin
              state_nxt = S_1A;
              bit_nxt   = 1'b1;
            end
            S_1A: begin
              zero_nxt = '0;
              if (zeros_q != 6'd0) begin
                state_nxt = S_Z;
                bit_nxt   = 1'b0;
              end else begin
                state_nxt = S_1B;
                bit_nxt   = 1'b1;
              end
            end
            S_Z: begin
              if (zero_inc == zeros_q) begin
                state_nxt = S_1B;
                bit_nxt   = 1'b1;
                zero_nxt  = '0;
              end else begin
                zero_nxt = zero_inc;
                bit_nxt  = 1'b0;
              end
            end
            default: begin
              sent_nxt = sent_inc;
              if (sent_inc == pats_q) begin
                state_nxt  = DONE;
                done_nxt   = 1'b1;
                busy_nxt   = 1'b0;
                bit_nxt    = 1'b0;
                strobe_nxt = 1'b0;
              end else begin
                state_nxt = S_0;
                bit_nxt   = 1'b0;
              end
            end
          endcase
        end
      end

      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        bit_nxt   = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        bit_nxt   = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_50MHz) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      zero_cnt   <= '0;
      zeros_q    <= '0;
      pats_q     <= '0;
      sent_count <= '0;
      bit_out    <= 1'b0;
      bit_strobe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      zero_cnt   <= zero_nxt;
      zeros_q    <= zeros_nxt;
      pats_q     <= pats_nxt;
      sent_count <= sent_nxt;
      bit_out    <= bit_nxt;
      bit_strobe <= strobe_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  // Decimal split of the sent count for the readout.
  always_comb begin
    ones_digit = 4'(sent_count % 6'd10);
    tens_digit = 4'(sent_count / 6'd10);
  end

  // Display registers; they follow sent_count one clock later.
  always_ff @(posedge clk_50MHz) begin
    if (!rst_n) begin
      DISP0 <= 7'b1000000;
      DISP1 <= 7'b1000000;
    end else begin
      DISP0 <= seg7(ones_digit);
      DISP1 <= seg7(tens_digit);
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Testbench for seq_pattern_tx with DIV_VALUE=2 (3 clocks per bit).
module tb_seq_pattern_tx;

  localparam int DIV = 2;
  localparam logic [6:0] SEG0 = 7'b1000000;
  localparam logic [6:0] SEG1 = 7'b1111001;
  localparam logic [6:0] SEG2 = 7'b0100100;
  localparam logic [6:0] SEG3 = 7'b0110000;

  logic       clk_50MHz;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [5:0] num_zeros;
  logic [5:0] num_patterns;
  logic       bit_out;
  logic       bit_strobe;
  logic       busy;
  logic       done;
  logic [5:0] sent_count;
  logic [6:0] DISP0;
  logic [6:0] DISP1;

  int total = 0;
  int bad   = 0;

  seq_pattern_tx #(.DIV_VALUE(DIV)) dut (
    .clk_50MHz    (clk_50MHz),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .num_zeros    (num_zeros),
    .num_patterns (num_patterns),
    .bit_out      (bit_out),
    .bit_strobe   (bit_strobe),
    .busy         (busy),
    .done         (done),
    .sent_count   (sent_count),
    .DISP0        (DISP0),
    .DISP1        (DISP1)
  );

  initial clk_50MHz = 1'b0;
  always #5 clk_50MHz = ~clk_50MHz;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bit"},    32'(bit_out),    0);
    chk({tag, "_strobe"}, 32'(bit_strobe), 0);
    chk({tag, "_busy"},   32'(busy),       0);
    chk({tag, "_done"},   32'(done),       0);
    chk({tag, "_sent"},   32'(sent_count), 0);
    chk({tag, "_disp0"},  32'(DISP0),      32'(SEG0));
    chk({tag, "_disp1"},  32'(DISP1),      32'(SEG0));
  endtask

  // Launch a run and follow it cycle by cycle until busy drops.
  task automatic send_and_check(input int z, input int p, input int restart_at,
                                input bit start_in_done, input int exp_busy,
                                input int exp_strobes, input logic [6:0] exp_d0,
                                input logic [6:0] exp_d1);
    int cyc;
    int strobes;
    int len;
    int bidx;
    num_zeros    = 6'(z);
    num_patterns = 6'(p);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    strobes = 0;
    len = 3 + z;
    while (busy && cyc < 2000) begin
      bidx = (cyc / (DIV + 1)) % len;
      chk("bit_out", 32'(bit_out), 32'(bidx == 1 || bidx == len - 1));
      chk("bit_strobe", 32'(bit_strobe), 32'((cyc % (DIV + 1)) == 0));
      chk("done_early", 32'(done), 0);
      strobes += int'(bit_strobe);
      start = (cyc == restart_at);
      cyc++;
      tick();
      start = 1'b0;
    end
    chk("busy_cycles", cyc, exp_busy);
    chk("done_pulse", 32'(done), 1);
    chk("busy_in_done", 32'(busy), 0);
    chk("bit_in_done", 32'(bit_out), 0);
    chk("strobe_in_done", 32'(bit_strobe), 0);
    chk("strobe_count", strobes, exp_strobes);
    chk("sent_count", 32'(sent_count), p);
    if (start_in_done) start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_clear", 32'(done), 0);
    chk("busy_after", 32'(busy), 0);
    chk("disp0", 32'(DISP0), 32'(exp_d0));
    chk("disp1", 32'(DISP1), 32'(exp_d1));
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    num_zeros    = '0;
    num_patterns = '0;
    tick();
    tick();
    chk_reset_vals("por");
    rst_n = 1'b1;
    tick();

    // 1: zeros=2, patterns=1 -> 0,1,0,0,1 ; 15 busy clocks, 5 strobes
    send_and_check(2, 1, -1, 1'b0, 15, 5, SEG1, SEG0);

    // 2: zeros=0, patterns=3 -> 27 clocks, 9 strobes; start in DONE ignored
    send_and_check(0, 3, -1, 1'b1, 27, 9, SEG3, SEG0);

    // 3: patterns=0 -> immediate done, nothing sent
    send_and_check(5, 0, -1, 1'b0, 0, 0, SEG0, SEG0);

    // 4: zeros=1, patterns=5, abort in 3rd pattern's zero bit (cycles 30..32)
    num_zeros    = 6'd1;
    num_patterns = 6'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("abort_pre_sent", 32'(sent_count), 2);
    chk("abort_pre_bit", 32'(bit_out), 0);
    chk("abort_pre_busy", 32'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_bit", 32'(bit_out), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sent", 32'(sent_count), 2);
    tick();
    chk("abort_no_done", 32'(done), 0);
    chk("abort_idle_busy", 32'(busy), 0);
    chk("abort_disp0", 32'(DISP0), 32'(SEG2));
    send_and_check(2, 1, -1, 1'b0, 15, 5, SEG1, SEG0);

    // 5: reset in 2nd pattern's first 1 bit (zeros=3: cycles 21..23)
    num_zeros    = 6'd3;
    num_patterns = 6'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 22; i++) tick();
    chk("rst_pre_bit", 32'(bit_out), 1);
    chk("rst_pre_sent", 32'(sent_count), 1);
    chk("rst_pre_disp0", 32'(DISP0), 32'(SEG1));
    rst_n = 1'b0;
    tick();
    chk_reset_vals("midrst");
    rst_n = 1'b1;
    tick();
    chk("midrst_idle_busy", 32'(busy), 0);
    send_and_check(1, 2, -1, 1'b0, 24, 8, SEG2, SEG0);

    // 6: zeros=0, patterns=12, start pulsed while busy -> ignored
    send_and_check(0, 12, 10, 1'b0, 108, 36, SEG2, SEG1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
